// File: rtl/t05_pkg.sv
// Shared types and constants for the team_05 histogram/Huffman datapath.
package t05_pkg;

  localparam int         NUM_BINS_DEF = 256;
  localparam logic [7:0] EOF_BYTE     = 8'h1A;

  typedef enum logic [2:0] {
    IDLE,
    SCAN_REQ,
    SCAN_CMP,
    CLR1,
    CLR2,
    DONE
  } state_t;

endpackage

// File: rtl/t05_min2_tracker.sv
// Tracks the two smallest non-zero values seen plus a saturating count; one-cycle register update.
// Next-state copies of least1_idx/found are exported so the caller can act on the final sample.
module t05_min2_tracker #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              upd,
  input  logic [ADDR_W-1:0] idx,
  input  logic [CNT_W-1:0]  val,
  output logic [ADDR_W-1:0] least1_idx,
  output logic [CNT_W-1:0]  least1_cnt,
  output logic [ADDR_W-1:0] least2_idx,
  output logic [CNT_W-1:0]  least2_cnt,
  output logic [1:0]        found,
  output logic [ADDR_W-1:0] least1_idx_nxt,
  output logic [1:0]        found_nxt
);

  logic [CNT_W-1:0]  least1_cnt_nxt;
  logic [ADDR_W-1:0] least2_idx_nxt;
  logic [CNT_W-1:0]  least2_cnt_nxt;

  // Emptiness is implied by found: least1 is empty at 0, least2 below 2.
  always_comb begin
    least1_idx_nxt = least1_idx;
    least1_cnt_nxt = least1_cnt;
    least2_idx_nxt = least2_idx;
    least2_cnt_nxt = least2_cnt;
    found_nxt      = found;
    if (clr) begin
      least1_idx_nxt = '0;
      least1_cnt_nxt = '0;
      least2_idx_nxt = '0;
      least2_cnt_nxt = '0;
      found_nxt      = 2'd0;
    end else if (upd && (val != '0)) begin
      if ((found == 2'd0) || (val < least1_cnt)) begin
        least2_idx_nxt = least1_idx;
        least2_cnt_nxt = least1_cnt;
        least1_idx_nxt = idx;
        least1_cnt_nxt = val;
      end else if ((found != 2'd2) || (val < least2_cnt)) begin
        least2_idx_nxt = idx;
        least2_cnt_nxt = val;
      end
      if (found != 2'd2) found_nxt = found + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      least1_idx <= '0;
      least1_cnt <= '0;
      least2_idx <= '0;
      least2_cnt <= '0;
      found      <= 2'd0;
    end else begin
      least1_idx <= least1_idx_nxt;
      least1_cnt <= least1_cnt_nxt;
      least2_idx <= least2_idx_nxt;
      least2_cnt <= least2_cnt_nxt;
      found      <= found_nxt;
    end
  end

endmodule

// File: rtl/t05_hist_min_scan.sv
// Scans the histogram SRAM for the two smallest non-zero bins, then zeroes them.
// Latency NUM_BINS*(k+1) + k per clear + 1 for a k-cycle ack; each SRAM request is held until ack.
module t05_hist_min_scan
  import t05_pkg::*;
#(
  parameter int NUM_BINS = NUM_BINS_DEF,
  parameter int ADDR_W   = 8,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sram_ack,
  input  logic [CNT_W-1:0]  sram_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [CNT_W-1:0]  sram_wdata,
  output logic              sram_rd_en,
  output logic              sram_wr_en,
  output logic [ADDR_W-1:0] least1_idx,
  output logic [CNT_W-1:0]  least1_cnt,
  output logic [ADDR_W-1:0] least2_idx,
  output logic [CNT_W-1:0]  least2_cnt,
  output logic [1:0]        found,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BINS - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  rdata_q;
  logic [ADDR_W-1:0] least1_idx_nxt;
  logic [1:0]        found_nxt;

  assign sram_wdata = '0;

  t05_min2_tracker #(
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) u_tracker (
    .clk           (clk),
    .rst           (rst),
    .clr           ((state == IDLE) && start),
    .upd           (state == SCAN_CMP),
    .idx           (addr),
    .val           (rdata_q),
    .least1_idx    (least1_idx),
    .least1_cnt    (least1_cnt),
    .least2_idx    (least2_idx),
    .least2_cnt    (least2_cnt),
    .found         (found),
    .least1_idx_nxt(least1_idx_nxt),
    .found_nxt     (found_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      rdata_q    <= '0;
      sram_addr  <= '0;
      sram_rd_en <= 1'b0;
      sram_wr_en <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SCAN_REQ;
            addr       <= '0;
            sram_addr  <= '0;
            sram_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        SCAN_REQ: begin
          if (sram_ack) begin
            rdata_q    <= sram_rdata;
            sram_rd_en <= 1'b0;
            state      <= SCAN_CMP;
          end
        end
        SCAN_CMP: begin
          // The last bin's comparison lands this cycle, so use the tracker's next values.
          if (addr == LAST_ADDR) begin
            if (found_nxt != 2'd0) begin
              state      <= CLR1;
              sram_addr  <= least1_idx_nxt;
              sram_wr_en <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else begin
            addr       <= addr + 1'b1;
            sram_addr  <= addr + 1'b1;
            sram_rd_en <= 1'b1;
            state      <= SCAN_REQ;
          end
        end
        CLR1: begin
          if (sram_ack) begin
            if (found == 2'd2) begin
              sram_addr <= least2_idx;
              state     <= CLR2;
            end else begin
              sram_wr_en <= 1'b0;
              state      <= DONE;
              done       <= 1'b1;
            end
          end
        end
        CLR2: begin
          if (sram_ack) begin
            sram_wr_en <= 1'b0;
            state      <= DONE;
            done       <= 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          sram_rd_en <= 1'b0;
          sram_wr_en <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_t05_hist_min_scan.sv
// Directed bench: SRAM model acking 2 cycles after each request, scoreboard checked on done.
module tb_t05_hist_min_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sram_ack = 1'b0;
  logic [31:0] sram_rdata = '0;
  logic [7:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_rd_en, sram_wr_en;
  logic [7:0]  least1_idx, least2_idx;
  logic [31:0] least1_cnt, least2_cnt;
  logic [1:0]  found;
  logic        busy, done;

  typedef struct {
    int l1_idx;
    int l1_cnt;
    int l2_idx;
    int l2_cnt;
    int found;
    int cycles;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem[256];
  int          wr_log[$];
  int          cyc = 0;
  int          start_cyc = 0;
  int          errors = 0;
  int          checks = 0;
  bit          overlap = 1'b0;

  t05_hist_min_scan dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sram_ack  (sram_ack),
    .sram_rdata(sram_rdata),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rd_en(sram_rd_en),
    .sram_wr_en(sram_wr_en),
    .least1_idx(least1_idx),
    .least1_cnt(least1_cnt),
    .least2_idx(least2_idx),
    .least2_cnt(least2_cnt),
    .found     (found),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: ack is visible in the second cycle of every request.
  always @(posedge clk) begin
    if ((sram_rd_en || sram_wr_en) && !sram_ack) begin
      sram_ack   <= 1'b1;
      sram_rdata <= mem[sram_addr];
      if (sram_wr_en) begin
        mem[sram_addr] = sram_wdata;
        wr_log.push_back(int'(sram_addr));
      end
    end else begin
      sram_ack <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sram_rd_en && sram_wr_en) overlap = 1'b1;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("least1_idx", 32'(least1_idx), 32'(e.l1_idx));
        chk("least1_cnt", least1_cnt, 32'(e.l1_cnt));
        chk("least2_idx", 32'(least2_idx), 32'(e.l2_idx));
        chk("least2_cnt", least2_cnt, 32'(e.l2_cnt));
        chk("found", 32'(found), 32'(e.found));
        chk("latency", 32'(cyc - start_cyc + 1), 32'(e.cycles));
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
    wr_log.delete();
  endtask

  task automatic load_t1();
    clear_mem();
    mem[65] = 32'd5;
    mem[66] = 32'd2;
    mem[67] = 32'd9;
  endtask

  task automatic expect_res(input int l1i, input int l1c, input int l2i, input int l2c,
                            input int f, input int cy);
    exp_t e;
    e.l1_idx = l1i; e.l1_cnt = l1c; e.l2_idx = l2i; e.l2_cnt = l2c;
    e.found = f; e.cycles = cy;
    sb.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("scan_timeout", 32'd0, 32'd1);
      sb.delete();
    end
  endtask

  task automatic wait_addr(input int a);
    bit hit = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sram_rd_en && int'(sram_addr) == a) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reach_addr", 32'(hit), 32'd1);
  endtask

  task automatic check_t1_writes();
    chk("t1_mem65", mem[65], 32'd0);
    chk("t1_mem66", mem[66], 32'd0);
    chk("t1_mem67", mem[67], 32'd9);
    chk("t1_nwr", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      chk("t1_wr0", 32'(wr_log[0]), 32'd66);
      chk("t1_wr1", 32'(wr_log[1]), 32'd65);
    end
  endtask

  initial begin
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", 32'(sram_rd_en), 32'd0);
    chk("rst_wr_en", 32'(sram_wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_found", 32'(found), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_l1", least1_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic pair: 66 smallest, 65 next.
    load_t1();
    expect_res(66, 2, 65, 5, 2, 773);
    pulse_start();
    wait_idle();
    check_t1_writes();

    // Equal counts: lower indices win.
    clear_mem();
    mem[10] = 32'd3; mem[200] = 32'd3; mem[20] = 32'd3;
    expect_res(10, 3, 20, 3, 2, 773);
    pulse_start();
    wait_idle();
    chk("t2_mem200", mem[200], 32'd3);
    chk("t2_nwr", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      chk("t2_wr0", 32'(wr_log[0]), 32'd10);
      chk("t2_wr1", 32'(wr_log[1]), 32'd20);
    end

    // Single non-zero bin.
    clear_mem();
    mem[26] = 32'd7;
    expect_res(26, 7, 0, 0, 1, 771);
    pulse_start();
    wait_idle();
    chk("t3_nwr", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() == 1) chk("t3_wr0", 32'(wr_log[0]), 32'd26);
    chk("t3_mem26", mem[26], 32'd0);

    // Empty table.
    clear_mem();
    expect_res(0, 0, 0, 0, 0, 769);
    pulse_start();
    wait_idle();
    chk("t4_nwr", 32'(wr_log.size()), 32'd0);

    // Reset mid-scan, then a clean rescan.
    load_t1();
    pulse_start();
    wait_addr(100);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_rd_en", 32'(sram_rd_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_found", 32'(found), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_idle_rd", 32'(sram_rd_en | sram_wr_en), 32'd0);
    chk("abort_nwr", 32'(wr_log.size()), 32'd0);
    expect_res(66, 2, 65, 5, 2, 773);
    pulse_start();
    wait_idle();
    check_t1_writes();

    // Start while busy is ignored.
    load_t1();
    expect_res(66, 2, 65, 5, 2, 773);
    pulse_start();
    wait_addr(50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check_t1_writes();

    chk("rd_wr_overlap", 32'(overlap), 32'd0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
